// File: rtl/prefilter_ap_ctrl_driver.sv
// prefilter_ap_ctrl_driver: ap_ctrl_chain initiator for the module0_prefilter kernel.
// Launches a commanded number of invocations, drains them and reports progress,
// cycle counts and protocol errors.
// Optional stall watchdog with a sticky ERR state: define PREFILTER_CTRL_WATCHDOG_EN.
module prefilter_ap_ctrl_driver #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned WDOG_CYCLES  = 65536
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  input  logic             sink_ready,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] launched,
  output logic [CNT_W-1:0] completed,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] first_latency,
  output logic             protocol_err
);

  // Reject configurations the inflight accounting does not support.
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 3 || WDOG_CYCLES < 1) begin : g_param_check
    $error("prefilter_ap_ctrl_driver: MAX_INFLIGHT must be 1..3 and WDOG_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
`ifdef PREFILTER_CTRL_WATCHDOG_EN
    , S_ERR = 3'd4
`endif
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] target_q;
  logic [CYC_W-1:0] lat_cnt;
  logic             lat_started;
  logic             lat_done;
  logic             ap_start_d;
  logic             busy_d;
  logic             done_pulse_d;
  logic             wdog_trip;

  logic             run_drain;
  logic             accept;
  logic             launch_hs;
  logic             comp_hs;
  logic             err_ev;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] launched_n;
  logic [CNT_W-1:0] completed_n;
  logic [CNT_W-1:0] inflight_n;
  logic             launch_rule_n;

  // Handshake events and post-event counter values.
  assign run_drain   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign accept      = (state_q == S_IDLE) && cmd_start;
  assign inflight    = launched - completed;
  assign launch_hs   = ap_start && ap_ready;
  assign comp_hs     = ap_done && ap_continue && (inflight != '0);
  assign err_ev      = (ap_done && (inflight == '0)) || (ap_ready && !ap_start);
  assign launched_n  = launched + CNT_W'(launch_hs);
  assign completed_n = completed + CNT_W'(comp_hs);
  assign inflight_n  = launched_n - completed_n;
  assign launch_rule_n = (state_q == S_RUN) && (launched_n < target_q) &&
                         (inflight_n < CNT_W'(MAX_INFLIGHT)) && !cmd_abort;

`ifdef PREFILTER_CTRL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;

  // Idle-handshake counter: restarts on every launch or completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (!run_drain || launch_hs || comp_hs) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WD_W'(WDOG_CYCLES)) begin
      wdog_cnt <= wdog_cnt + WD_W'(1);
    end
  end

  assign wdog_trip = run_drain && (wdog_cnt == WD_W'(WDOG_CYCLES)) &&
                     ((inflight != '0) || ap_start);
`else
  assign wdog_trip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (cmd_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
`ifdef PREFILTER_CTRL_WATCHDOG_EN
        if (wdog_trip) begin
          state_d = S_ERR;
        end else
`endif
        if ((launched == target_q) || (cmd_abort && !ap_start)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
`ifdef PREFILTER_CTRL_WATCHDOG_EN
        if (wdog_trip) begin
          state_d = S_ERR;
        end else
`endif
        if (inflight_n == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef PREFILTER_CTRL_WATCHDOG_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: continue is combinational, the rest feed output registers.
  always_comb begin
    ap_continue  = sink_ready && run_drain;
    ap_start_d   = 1'b0;
    busy_d       = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_pulse_d = (state_d == S_DONE);
    if (wdog_trip) begin
      ap_start_d = 1'b0;
    end else if (ap_start && !ap_ready) begin
      ap_start_d = 1'b1;
    end else begin
      ap_start_d = launch_rule_n;
    end
  end

  // Output registers, counters and latency measurement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ap_start      <= 1'b0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      target_q      <= '0;
      launched      <= '0;
      completed     <= '0;
      cycle_count   <= '0;
      first_latency <= '0;
      lat_cnt       <= '0;
      lat_started   <= 1'b0;
      lat_done      <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      ap_start   <= ap_start_d;
      busy       <= busy_d;
      done_pulse <= done_pulse_d;
      if (accept) begin
        target_q      <= cmd_count;
        launched      <= '0;
        completed     <= '0;
        cycle_count   <= '0;
        first_latency <= '0;
        lat_cnt       <= '0;
        lat_started   <= 1'b0;
        lat_done      <= 1'b0;
        protocol_err  <= 1'b0;
      end else begin
        launched  <= launched_n;
        completed <= completed_n;
        if (run_drain && (cycle_count != '1)) begin
          cycle_count <= cycle_count + CYC_W'(1);
        end
        if (ap_start) begin
          lat_started <= 1'b1;
        end
        if ((ap_start || lat_started) && !lat_done && (lat_cnt != '1)) begin
          lat_cnt <= lat_cnt + CYC_W'(1);
        end
        if (comp_hs && !lat_done) begin
          lat_done      <= 1'b1;
          first_latency <= lat_cnt;
        end
        if (err_ev || wdog_trip) begin
          protocol_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefilter_ap_ctrl_driver.sv
// Directed testbench for prefilter_ap_ctrl_driver with a behavioural kernel model.
module tb_prefilter_ap_ctrl_driver;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CYC_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_start;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;
  logic             sink_ready;
  logic             ap_start;
  logic             ap_continue;
  logic             ap_ready;
  logic             ap_done;
  logic             busy;
  logic             done_pulse;
  logic [CNT_W-1:0] launched;
  logic [CNT_W-1:0] completed;
  logic [CYC_W-1:0] cycle_count;
  logic [CYC_W-1:0] first_latency;
  logic             protocol_err;

  logic k_ready, k_done, inj_ready, inj_done;
  assign ap_ready = k_ready | inj_ready;
  assign ap_done  = k_done | inj_done;

  prefilter_ap_ctrl_driver #(
    .CNT_W(CNT_W), .CYC_W(CYC_W), .MAX_INFLIGHT(2), .WDOG_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_count(cmd_count),
    .cmd_abort(cmd_abort), .sink_ready(sink_ready), .ap_start(ap_start),
    .ap_continue(ap_continue), .ap_ready(ap_ready), .ap_done(ap_done),
    .busy(busy), .done_pulse(done_pulse), .launched(launched),
    .completed(completed), .cycle_count(cycle_count),
    .first_latency(first_latency), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Kernel model: ap_ready rdelay cycles after ap_start, ap_done ddelay cycles after the
  // launch handshake, held until ap_continue.
  int cyc = 0;
  int rdelay = 1;
  int ddelay = 27;
  bit ready_en = 1'b1;
  bit done_en = 1'b1;
  int wait_cnt = 0;
  int dq[$];
  logic p_start, p_ready, p_kdone, p_cont;
  int done_pulses = 0;
  int viol = 0;

  initial begin
    k_ready = 1'b0;
    k_done  = 1'b0;
    p_start = 1'b0;
    p_ready = 1'b0;
    p_kdone = 1'b0;
    p_cont  = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        wait_cnt = 0;
        dq.delete();
      end else begin
        if (p_start && p_ready) begin
          dq.push_back(cyc - 1 + ddelay);
          wait_cnt = 0;
        end else if (p_start) begin
          wait_cnt++;
        end
        if (p_kdone && p_cont && dq.size() > 0) dq.pop_front();
      end
      k_ready = ready_en && ap_start && (wait_cnt >= rdelay);
      k_done  = done_en && (dq.size() > 0) && (cyc >= dq[0]);
      #1;
      p_start = ap_start;
      p_ready = ap_ready;
      p_kdone = k_done;
      p_cont  = ap_continue;
      if (done_pulse) done_pulses++;
      if (ap_start && ((launched - completed) == CNT_W'(2))) viol++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_cmd(input logic [CNT_W-1:0] n);
    @(negedge clock);
    cmd_count = n;
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done_pulse && n < limit) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, done_pulse, 1);
  endtask

  initial begin
    int pulses0;
    int n;
    reset = 1'b1;
    cmd_start = 1'b0;
    cmd_count = '0;
    cmd_abort = 1'b0;
    sink_ready = 1'b1;
    inj_ready = 1'b0;
    inj_done = 1'b0;
    tick(3);
    check_eq("rst_ap_start", ap_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_counters", {launched, completed, cycle_count}, 0);
    check_eq("rst_ap_continue", ap_continue, 0);
    reset = 1'b0;
    tick(2);
    check_eq("idle_busy", busy, 0);

    // Three invocations, ready after 1 cycle, done 27 cycles after the handshake.
    pulses0 = done_pulses;
    start_cmd(3);
    check_eq("t1_busy", busy, 1);
    tick(5);
    start_cmd(9);
    wait_done("t1_done", 200);
    tick(2);
    check_eq("t1_pulses", done_pulses - pulses0, 1);
    check_eq("t1_launched", launched, 3);
    check_eq("t1_completed", completed, 3);
    check_eq("t1_first_lat", first_latency, 28);
    check_eq("t1_cycles", cycle_count, 59);
    check_eq("t1_perr", protocol_err, 0);
    check_eq("t1_idle", busy, 0);

    // Five invocations with ap_done withheld: inflight caps at two.
    ddelay = 5;
    done_en = 1'b0;
    start_cmd(5);
    tick(40);
    check_eq("t2_launched_cap", launched, 2);
    check_eq("t2_completed_0", completed, 0);
    check_eq("t2_start_low", ap_start, 0);
    done_en = 1'b1;
    wait_done("t2_done", 300);
    check_eq("t2_completed", completed, 5);
    check_eq("t2_launched", launched, 5);
    check_eq("t2_no_start_at_max", viol, 0);

    // Abort while a start is pending with a 3-cycle ready delay.
    rdelay = 3;
    ddelay = 27;
    start_cmd(4);
    n = 0;
    while (launched != CNT_W'(1) && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("t3_first_launch", launched, 1);
    cmd_abort = 1'b1;
    tick(1);
    check_eq("t3_start_held", ap_start, 1);
    wait_done("t3_done", 200);
    check_eq("t3_launched", launched, 2);
    check_eq("t3_completed", completed, 2);
    cmd_abort = 1'b0;
    rdelay = 1;
    tick(2);

    // Zero-length command goes straight to DONE.
    start_cmd(0);
    check_eq("t4_done_next", done_pulse, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_counters", {launched, completed, cycle_count, first_latency}, 0);
    check_eq("t4_no_start", ap_start, 0);
    tick(1);
    check_eq("t4_pulse_1cyc", done_pulse, 0);

    // ap_ready without ap_start is a protocol error; counters untouched.
    @(negedge clock);
    inj_ready = 1'b1;
    @(negedge clock);
    inj_ready = 1'b0;
    check_eq("t4_ready_err", protocol_err, 1);
    check_eq("t4_ready_nolaunch", launched, 0);

    // Spurious ap_done with nothing inflight, then asynchronous reset mid-run.
    ready_en = 1'b0;
    start_cmd(2);
    check_eq("t5_err_cleared", protocol_err, 0);
    tick(3);
    check_eq("t5_start_pending", ap_start, 1);
    inj_done = 1'b1;
    @(negedge clock);
    inj_done = 1'b0;
    tick(1);
    check_eq("t5_done_err", protocol_err, 1);
    check_eq("t5_completed", completed, 0);
    tick(2);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_start", ap_start, 0);
    check_eq("t5_async_busy", busy, 0);
    check_eq("t5_async_perr", protocol_err, 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check_eq("t5_post_busy", busy, 0);
    check_eq("t5_post_outputs", {ap_start, ap_continue, done_pulse, launched, cycle_count}, 0);
    ready_en = 1'b1;

`ifdef PREFILTER_CTRL_WATCHDOG_EN
    // Kernel never accepts: watchdog forces ERR.
    ready_en = 1'b0;
    start_cmd(1);
    tick(80);
    check_eq("wd_still_busy", busy, 1);
    n = 0;
    while (busy && n < 60) begin
      tick(1);
      n++;
    end
    check_eq("wd_busy", busy, 0);
    check_eq("wd_start", ap_start, 0);
    check_eq("wd_perr", protocol_err, 1);
    check_eq("wd_continue", ap_continue, 0);
    start_cmd(1);
    tick(3);
    check_eq("wd_stuck", busy, 0);
    check_eq("wd_stuck_perr", protocol_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL tb_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
